// File: rtl/rr_fifo_bank_if.sv
// Bundle of the rr_fifo_bank producer/consumer signals.
// The master side drives the pushes and out_ready. The slave side is the FIFO bank.
interface rr_fifo_bank_if #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 8,
  parameter int NCH    = 4,
  parameter int PTRWID = $clog2(DEPTH) + 1,
  parameter int CHWID  = $clog2(NCH)
);
  logic [NCH-1:0]        push;
  logic [NCH*WIDTH-1:0]  data_in;
  logic [NCH-1:0]        full;
  logic [NCH-1:0]        empty;
  logic [NCH*PTRWID-1:0] count;
  logic [NCH-1:0]        overflow;
  logic                  out_valid;
  logic                  out_ready;
  logic [WIDTH-1:0]      out_data;
  logic [CHWID-1:0]      out_ch;

  modport master (
    output push, data_in, out_ready,
    input  full, empty, count, overflow, out_valid, out_data, out_ch
  );

  modport slave (
    input  push, data_in, out_ready,
    output full, empty, count, overflow, out_valid, out_data, out_ch
  );
endinterface

// File: rtl/rr_fifo_bank.sv
// NCH first-word-fall-through FIFOs drained through one valid/ready port.
// A round-robin arbiter picks the channel, and it holds that pick while the consumer stalls.
module rr_fifo_bank #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 8,
  parameter int NCH    = 4,
  parameter int PTRWID = $clog2(DEPTH) + 1,
  parameter int CHWID  = $clog2(NCH)
) (
  input logic          clk,
  input logic          rst,
  rr_fifo_bank_if.slave bus
);
  logic [WIDTH-1:0]      mem    [NCH][DEPTH];
  logic [PTRWID-1:0]     wr_ptr [NCH];
  logic [PTRWID-1:0]     rd_ptr [NCH];
  logic [NCH-1:0]        full_v, empty_v, do_push, do_pop, ovf_q;
  logic [NCH*PTRWID-1:0] count_v;
  logic [CHWID-1:0]      last_ch, held_ch, sel, cand;
  logic                  locked, found, any_valid, xfer;

  always_comb begin
    full_v  = '0;
    empty_v = '0;
    count_v = '0;
    do_push = '0;
    for (int c = 0; c < NCH; c++) begin
      empty_v[c] = (wr_ptr[c] == rd_ptr[c]);
      full_v[c]  = (wr_ptr[c][PTRWID-2:0] == rd_ptr[c][PTRWID-2:0]) &&
                   (wr_ptr[c][PTRWID-1] != rd_ptr[c][PTRWID-1]);
      count_v[c*PTRWID +: PTRWID] = wr_ptr[c] - rd_ptr[c];
      do_push[c] = bus.push[c] & ~full_v[c];
    end
  end

  assign any_valid = |(~empty_v);
  assign xfer      = any_valid & bus.out_ready;

  // The scan starts one past the last granted channel. A stalled grant stays locked.
  always_comb begin
    sel   = held_ch;
    found = 1'b0;
    cand  = '0;
    if (!locked) begin
      sel = '0;
      for (int i = 1; i <= NCH; i++) begin
        cand = CHWID'((int'(last_ch) + i) % NCH);
        if (!found && !empty_v[cand]) begin
          sel   = cand;
          found = 1'b1;
        end
      end
    end
  end

  always_comb begin
    do_pop = '0;
    for (int c = 0; c < NCH; c++)
      do_pop[c] = xfer && (sel == CHWID'(c));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < NCH; c++) begin
        wr_ptr[c] <= '0;
        rd_ptr[c] <= '0;
      end
      ovf_q   <= '0;
      last_ch <= CHWID'(NCH - 1);
      held_ch <= '0;
      locked  <= 1'b0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (do_push[c]) wr_ptr[c] <= wr_ptr[c] + PTRWID'(1);
        if (do_pop[c])  rd_ptr[c] <= rd_ptr[c] + PTRWID'(1);
        if (bus.push[c] && full_v[c]) ovf_q[c] <= 1'b1;
      end
      if (xfer) begin
        last_ch <= sel;
        locked  <= 1'b0;
      end else if (any_valid) begin
        held_ch <= sel;
        locked  <= 1'b1;
      end
    end
  end

  // The storage has no reset. Its contents cannot be seen while the pointers say empty.
  always_ff @(posedge clk) begin
    for (int c = 0; c < NCH; c++)
      if (do_push[c]) mem[c][wr_ptr[c][PTRWID-2:0]] <= bus.data_in[c*WIDTH +: WIDTH];
  end

  assign bus.full      = full_v;
  assign bus.empty     = empty_v;
  assign bus.count     = count_v;
  assign bus.overflow  = ovf_q;
  assign bus.out_valid = any_valid;
  assign bus.out_ch    = any_valid ? sel : '0;
  assign bus.out_data  = any_valid ? mem[sel][rd_ptr[sel][PTRWID-2:0]] : '0;
endmodule

// File: tb/tb_rr_fifo_bank.sv
// Bench for rr_fifo_bank. A queue-per-channel model predicts every output.
// Each scenario task drives stimulus and checks the outputs inline.
module tb_rr_fifo_bank;
  localparam int WIDTH  = 8;
  localparam int DEPTH  = 8;
  localparam int NCH    = 4;
  localparam int PTRWID = 4;
  localparam int CHWID  = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rr_fifo_bank_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NCH(NCH), .PTRWID(PTRWID), .CHWID(CHWID)) bus ();
  rr_fifo_bank #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NCH(NCH), .PTRWID(PTRWID), .CHWID(CHWID)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  logic [WIDTH-1:0] mq [NCH][$];
  logic [NCH-1:0]   m_ovf;
  int               m_last, m_held;
  bit               m_lock;
  int               n_tests, n_fail;

  function automatic bit exp_valid();
    for (int c = 0; c < NCH; c++) if (mq[c].size() != 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int exp_sel();
    if (m_lock) return m_held;
    for (int i = 1; i <= NCH; i++) begin
      int c = (m_last + i) % NCH;
      if (mq[c].size() != 0) return c;
    end
    return 0;
  endfunction

  function automatic logic [WIDTH-1:0] exp_data();
    if (!exp_valid()) return '0;
    return mq[exp_sel()][0];
  endfunction

  function automatic logic [NCH*PTRWID-1:0] exp_count();
    logic [NCH*PTRWID-1:0] v = '0;
    for (int c = 0; c < NCH; c++) v[c*PTRWID +: PTRWID] = PTRWID'(mq[c].size());
    return v;
  endfunction

  function automatic logic [NCH-1:0] exp_full();
    logic [NCH-1:0] v = '0;
    for (int c = 0; c < NCH; c++) v[c] = (mq[c].size() == DEPTH);
    return v;
  endfunction

  function automatic logic [NCH-1:0] exp_empty();
    logic [NCH-1:0] v = '0;
    for (int c = 0; c < NCH; c++) v[c] = (mq[c].size() == 0);
    return v;
  endfunction

  task automatic model_clock(input logic [NCH-1:0] p, input logic [NCH*WIDTH-1:0] d,
                             input logic r, input logic rs);
    int  sz [NCH];
    bit  v;
    int  s;
    if (rs) begin
      for (int c = 0; c < NCH; c++) mq[c].delete();
      m_ovf  = '0;
      m_last = NCH - 1;
      m_lock = 1'b0;
      m_held = 0;
      return;
    end
    v = exp_valid();
    s = exp_sel();
    for (int c = 0; c < NCH; c++) sz[c] = mq[c].size();
    if (v && r) begin
      void'(mq[s].pop_front());
      m_last = s;
      m_lock = 1'b0;
    end else if (v) begin
      m_lock = 1'b1;
      m_held = s;
    end
    for (int c = 0; c < NCH; c++)
      if (p[c]) begin
        if (sz[c] == DEPTH) m_ovf[c] = 1'b1;
        else mq[c].push_back(d[c*WIDTH +: WIDTH]);
      end
  endtask

  task automatic cycle(input logic [NCH-1:0] p, input logic [NCH*WIDTH-1:0] d,
                       input logic r, input logic rs);
    bus.push      = p;
    bus.data_in   = d;
    bus.out_ready = r;
    rst           = rs;
    model_clock(p, d, r, rs);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    cycle('0, '0, 1'b0, 1'b1);
    cycle('0, '0, 1'b0, 1'b1);
    cycle('0, '0, 1'b0, 1'b0);
    n_tests++; if (bus.empty !== {NCH{1'b1}}) begin n_fail++; $display("FAIL reset_empty got %b exp 1111", bus.empty); end
    n_tests++; if (bus.full !== '0) begin n_fail++; $display("FAIL reset_full got %b exp 0", bus.full); end
    n_tests++; if (bus.count !== '0) begin n_fail++; $display("FAIL reset_count got %h exp 0", bus.count); end
    n_tests++; if (bus.overflow !== '0) begin n_fail++; $display("FAIL reset_overflow got %b exp 0", bus.overflow); end
    n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", bus.out_valid); end
    n_tests++; if (bus.out_data !== '0) begin n_fail++; $display("FAIL reset_data got %h exp 0", bus.out_data); end
    n_tests++; if (bus.out_ch !== '0) begin n_fail++; $display("FAIL reset_ch got %0d exp 0", bus.out_ch); end
  endtask

  task automatic test_single_push();
    cycle('0, '0, 1'b0, 1'b1);
    cycle(4'b0001, 32'h11, 1'b0, 1'b0);
    n_tests++; if (bus.count[PTRWID-1:0] !== 4'd1) begin n_fail++; $display("FAIL single_count got %0d exp 1", bus.count[PTRWID-1:0]); end
    for (int k = 0; k < 4; k++) begin
      n_tests++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid[%0d] got %b exp 1", k, bus.out_valid); end
      n_tests++; if (bus.out_data !== 8'h11) begin n_fail++; $display("FAIL single_data[%0d] got %h exp 11", k, bus.out_data); end
      n_tests++; if (bus.out_ch !== 2'd0) begin n_fail++; $display("FAIL single_ch[%0d] got %0d exp 0", k, bus.out_ch); end
      if (k < 3) cycle('0, '0, 1'b0, 1'b0);
    end
    cycle('0, '0, 1'b1, 1'b0);
    n_tests++; if (bus.empty[0] !== 1'b1) begin n_fail++; $display("FAIL single_drain_empty got %b exp 1", bus.empty[0]); end
    n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL single_drain_valid got %b exp 0", bus.out_valid); end
  endtask

  task automatic test_overflow();
    logic [NCH*WIDTH-1:0] d;
    cycle('0, '0, 1'b0, 1'b1);
    for (int i = 0; i < DEPTH; i++) begin
      d = '0; d[1*WIDTH +: WIDTH] = WIDTH'(i);
      cycle(4'b0010, d, 1'b0, 1'b0);
    end
    n_tests++; if (bus.full[1] !== 1'b1) begin n_fail++; $display("FAIL ovf_full got %b exp 1", bus.full[1]); end
    n_tests++; if (bus.count[PTRWID +: PTRWID] !== 4'd8) begin n_fail++; $display("FAIL ovf_count got %0d exp 8", bus.count[PTRWID +: PTRWID]); end
    n_tests++; if (bus.overflow[1] !== 1'b0) begin n_fail++; $display("FAIL ovf_early got %b exp 0", bus.overflow[1]); end
    d = '0; d[1*WIDTH +: WIDTH] = 8'hFF;
    cycle(4'b0010, d, 1'b0, 1'b0);
    n_tests++; if (bus.overflow[1] !== 1'b1) begin n_fail++; $display("FAIL ovf_flag got %b exp 1", bus.overflow[1]); end
    n_tests++; if (bus.count[PTRWID +: PTRWID] !== 4'd8) begin n_fail++; $display("FAIL ovf_count_held got %0d exp 8", bus.count[PTRWID +: PTRWID]); end
    for (int i = 0; i < DEPTH; i++) begin
      n_tests++; if (bus.out_ch !== 2'd1) begin n_fail++; $display("FAIL ovf_drain_ch[%0d] got %0d exp 1", i, bus.out_ch); end
      n_tests++; if (bus.out_data !== WIDTH'(i)) begin n_fail++; $display("FAIL ovf_drain_data[%0d] got %h exp %h", i, bus.out_data, i); end
      cycle('0, '0, 1'b1, 1'b0);
    end
    n_tests++; if (bus.empty[1] !== 1'b1) begin n_fail++; $display("FAIL ovf_drained got %b exp 1", bus.empty[1]); end
    n_tests++; if (bus.overflow[1] !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got %b exp 1", bus.overflow[1]); end
  endtask

  task automatic test_round_robin();
    logic [NCH*WIDTH-1:0] d;
    int exp_ch [6] = '{0, 2, 3, 0, 2, 3};
    cycle('0, '0, 1'b0, 1'b1);
    for (int k = 0; k < 2; k++) begin
      for (int c = 0; c < NCH; c++) d[c*WIDTH +: WIDTH] = WIDTH'(c * 16 + k);
      cycle(4'b1101, d, 1'b0, 1'b0);
    end
    for (int j = 0; j < 6; j++) begin
      n_tests++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL rr_valid[%0d] got %b exp 1", j, bus.out_valid); end
      n_tests++; if (bus.out_ch !== CHWID'(exp_ch[j])) begin n_fail++; $display("FAIL rr_ch[%0d] got %0d exp %0d", j, bus.out_ch, exp_ch[j]); end
      n_tests++; if (bus.out_data !== WIDTH'(exp_ch[j] * 16 + j / 3)) begin n_fail++; $display("FAIL rr_data[%0d] got %h exp %h", j, bus.out_data, exp_ch[j] * 16 + j / 3); end
      cycle('0, '0, 1'b1, 1'b0);
    end
    n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rr_done_valid got %b exp 0", bus.out_valid); end
  endtask

  task automatic test_lock();
    logic [NCH*WIDTH-1:0] d;
    cycle('0, '0, 1'b0, 1'b1);
    d = '0; d[0 +: WIDTH] = 8'hA0; d[2*WIDTH +: WIDTH] = 8'hA2;
    cycle(4'b0101, d, 1'b0, 1'b0);
    n_tests++; if (bus.out_ch !== 2'd0) begin n_fail++; $display("FAIL lock_first_ch got %0d exp 0", bus.out_ch); end
    cycle('0, '0, 1'b1, 1'b0);
    d = '0; d[1*WIDTH +: WIDTH] = 8'hA1;
    cycle(4'b0010, d, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      n_tests++; if (bus.out_ch !== 2'd2) begin n_fail++; $display("FAIL lock_held_ch[%0d] got %0d exp 2", k, bus.out_ch); end
      n_tests++; if (bus.out_data !== 8'hA2) begin n_fail++; $display("FAIL lock_held_data[%0d] got %h exp a2", k, bus.out_data); end
      if (k < 2) cycle('0, '0, 1'b0, 1'b0);
    end
    cycle('0, '0, 1'b1, 1'b0);
    n_tests++; if (bus.out_ch !== 2'd1) begin n_fail++; $display("FAIL lock_next_ch got %0d exp 1", bus.out_ch); end
    n_tests++; if (bus.out_data !== 8'hA1) begin n_fail++; $display("FAIL lock_next_data got %h exp a1", bus.out_data); end
  endtask

  task automatic test_wrap();
    logic [NCH*WIDTH-1:0] d;
    logic p, r;
    int pushed = 0, popped = 0, cyc = 0;
    cycle('0, '0, 1'b0, 1'b1);
    while (popped < 20 && cyc < 400) begin
      p = (pushed < 20) && (mq[0].size() < DEPTH) && ($urandom_range(0, 2) != 0);
      r = ($urandom_range(0, 1) != 0);
      d = '0; d[0 +: WIDTH] = WIDTH'(pushed);
      if (p) pushed++;
      if (r && exp_valid()) popped++;
      cycle({3'b000, p}, d, r, 1'b0);
      cyc++;
      n_tests++; if (bus.count[PTRWID-1:0] !== PTRWID'(mq[0].size())) begin n_fail++; $display("FAIL wrap_count@%0d got %0d exp %0d", cyc, bus.count[PTRWID-1:0], mq[0].size()); end
      n_tests++; if (bus.count[PTRWID-1:0] > PTRWID'(DEPTH)) begin n_fail++; $display("FAIL wrap_count_max@%0d got %0d exp <=8", cyc, bus.count[PTRWID-1:0]); end
      n_tests++; if (bus.full[0] !== exp_full()[0] || bus.empty[0] !== exp_empty()[0]) begin n_fail++; $display("FAIL wrap_flags@%0d got f%b e%b exp f%b e%b", cyc, bus.full[0], bus.empty[0], exp_full()[0], exp_empty()[0]); end
      n_tests++; if (bus.out_data !== exp_data()) begin n_fail++; $display("FAIL wrap_data@%0d got %h exp %h", cyc, bus.out_data, exp_data()); end
    end
    n_tests++; if (popped != 20) begin n_fail++; $display("FAIL wrap_timeout got %0d pops exp 20", popped); end
  endtask

  task automatic test_random();
    logic [NCH-1:0] p;
    logic [NCH*WIDTH-1:0] d;
    logic r;
    int dens;
    cycle('0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 400; i++) begin
      dens = ((i / 100) % 2 == 0) ? 1 : 3;
      for (int c = 0; c < NCH; c++) p[c] = ($urandom_range(0, 3) < dens);
      for (int c = 0; c < NCH; c++) d[c*WIDTH +: WIDTH] = WIDTH'($urandom);
      r = ($urandom_range(0, 3) != 0);
      cycle(p, d, r, 1'b0);
      n_tests++; if (bus.out_valid !== exp_valid()) begin n_fail++; $display("FAIL rnd_valid@%0d got %b exp %b", i, bus.out_valid, exp_valid()); end
      n_tests++; if (bus.out_ch !== (exp_valid() ? CHWID'(exp_sel()) : CHWID'(0))) begin n_fail++; $display("FAIL rnd_ch@%0d got %0d exp %0d", i, bus.out_ch, exp_valid() ? exp_sel() : 0); end
      n_tests++; if (bus.out_data !== exp_data()) begin n_fail++; $display("FAIL rnd_data@%0d got %h exp %h", i, bus.out_data, exp_data()); end
      n_tests++; if (bus.count !== exp_count()) begin n_fail++; $display("FAIL rnd_count@%0d got %h exp %h", i, bus.count, exp_count()); end
      n_tests++; if (bus.full !== exp_full()) begin n_fail++; $display("FAIL rnd_full@%0d got %b exp %b", i, bus.full, exp_full()); end
      n_tests++; if (bus.empty !== exp_empty()) begin n_fail++; $display("FAIL rnd_empty@%0d got %b exp %b", i, bus.empty, exp_empty()); end
      n_tests++; if (bus.overflow !== m_ovf) begin n_fail++; $display("FAIL rnd_overflow@%0d got %b exp %b", i, bus.overflow, m_ovf); end
    end
  endtask

  task automatic test_reset_mid();
    logic [NCH*WIDTH-1:0] d;
    for (int i = 0; i < DEPTH + 1; i++) begin
      d = NCH*WIDTH'($urandom);
      cycle(4'b1000, d, 1'b0, 1'b0);
    end
    n_tests++; if (bus.overflow[3] !== 1'b1) begin n_fail++; $display("FAIL mid_pre_overflow got %b exp 1", bus.overflow[3]); end
    d = NCH*WIDTH'($urandom);
    cycle('1, d, 1'b1, 1'b1);
    n_tests++; if (bus.empty !== {NCH{1'b1}}) begin n_fail++; $display("FAIL mid_empty got %b exp 1111", bus.empty); end
    n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_valid got %b exp 0", bus.out_valid); end
    n_tests++; if (bus.overflow !== '0) begin n_fail++; $display("FAIL mid_overflow got %b exp 0", bus.overflow); end
    n_tests++; if (bus.count !== '0) begin n_fail++; $display("FAIL mid_count got %h exp 0", bus.count); end
    cycle('1, d, 1'b0, 1'b0);
    n_tests++; if (bus.out_ch !== 2'd0) begin n_fail++; $display("FAIL mid_first_grant got %0d exp 0", bus.out_ch); end
    n_tests++; if (bus.out_data !== d[0 +: WIDTH]) begin n_fail++; $display("FAIL mid_first_data got %h exp %h", bus.out_data, d[0 +: WIDTH]); end
  endtask

  initial begin
    n_tests       = 0;
    n_fail        = 0;
    rst           = 1'b1;
    bus.push      = '0;
    bus.data_in   = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_single_push();
    test_overflow();
    test_round_robin();
    test_lock();
    test_wrap();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
